// File: rtl/hq2x_scanout.sv
// -----------------------------------------------------------------------------
// hq2x_scanout
//
// Read-side sequencer for the four-bank hq2x output line buffer. Counts the
// banks the writer has completed, scans the oldest completed bank out one word
// per ce_pix in bank order 0,1,2,3,0, and presents registered pixels to the
// video output stage. Underrun and overflow are reported as sticky flags.
//
// Optional feature macro: HQ2X_SCANOUT_REPEAT_EN
//   defined   : at most 3 banks pending; the most recently released bank is kept
//               as "last shown" and is re-displayed on underrun (if one exists).
//   undefined : at most 4 banks pending; underrun lines are output as zeros.
//
// Ports
//   clk        : sole clock
//   reset_n    : asynchronous active-low reset
//   wr_done    : writer finished the current write bank (1-cycle pulse)
//   wr_ready   : writer may fill another bank
//   line_start : start of an output active line (1-cycle pulse)
//   ce_pix     : output pixel strobe
//   rdaddr     : buffer read address (registered)
//   rdbuf      : buffer read bank (registered)
//   q          : buffer read data, valid 1 clk after rdaddr/rdbuf
//   pix_out    : output pixel (holds between pulses)
//   pix_valid  : one pulse per consumed ce_pix, 2 clk after the strobe
//   underrun   : sticky, a line started with no completed bank
//   overflow   : sticky, wr_done arrived while wr_ready was low
//   clr_flags  : synchronous clear of both sticky flags (wins over set)
// -----------------------------------------------------------------------------
module hq2x_scanout #(
    parameter  int LENGTH = 320,
    parameter  int DWIDTH = 23,
    localparam int AW_RAW = $clog2(2 * LENGTH) - 1,
    localparam int AWIDTH = (AW_RAW > 10) ? 10 : ((AW_RAW < 0) ? 0 : AW_RAW)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              line_start,
    input  logic              ce_pix,
    output logic [AWIDTH:0]   rdaddr,
    output logic [1:0]        rdbuf,
    input  logic [DWIDTH:0]   q,
    output logic [DWIDTH:0]   pix_out,
    output logic              pix_valid,
    output logic              underrun,
    output logic              overflow,
    input  logic              clr_flags
);

    localparam int NWORDS = 2 * LENGTH;
    localparam int CW     = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

`ifdef HQ2X_SCANOUT_REPEAT_EN
    localparam logic [2:0] MAXF = 3'd3;
`else
    localparam logic [2:0] MAXF = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_fill;
    logic [1:0]      r_rd_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_repeat;      // current line re-shows the last bank
    logic            r_rd_v;        // a read was issued last cycle
    logic            r_rd_blank;    // ...and it belongs to a blank line
`ifdef HQ2X_SCANOUT_REPEAT_EN
    logic            r_shown;       // some bank has been released since reset
`endif

    logic            w_wr_ready;
    logic            w_accept;
    logic            w_last;
    logic            w_release;
    logic            w_wr_ok;
    logic            w_start_repeat;
    logic [2:0]      w_fill_post;
    logic [2:0]      w_fill_next;
    logic [1:0]      w_rd_idx_post;

    assign w_wr_ready = (r_fill < MAXF);
    assign wr_ready   = w_wr_ready;

    // A strobe coinciding with line_start belongs to no line and is dropped.
    assign w_accept   = ce_pix & ~line_start & (r_state != S_IDLE);
    assign w_last     = w_accept & (r_cnt == LAST_CNT);
    // A bank is released at the end of its line or when line_start aborts it;
    // a repeated line never owns a bank.
    assign w_release  = (r_state == S_ACTIVE) & ~r_repeat & (w_last | line_start);
    assign w_wr_ok    = wr_done & w_wr_ready;

    // The next line is judged on the fill left after this cycle's release.
    assign w_fill_post   = r_fill - {2'b00, w_release};
    assign w_rd_idx_post = r_rd_idx + {1'b0, w_release};

`ifdef HQ2X_SCANOUT_REPEAT_EN
    assign w_start_repeat = (w_fill_post == 3'd0) & (r_shown | w_release);
`else
    assign w_start_repeat = 1'b0;
`endif

    // NOTE: a default assignment first means no path leaves w_fill_next unassigned, so no latch.
    always_comb begin
        w_fill_next = r_fill;
        if (w_wr_ok && !w_release) begin
            w_fill_next = r_fill + 3'd1;
        end else if (!w_wr_ok && w_release) begin
            w_fill_next = r_fill - 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill   <= 3'd0;
            r_rd_idx <= 2'd0;
`ifdef HQ2X_SCANOUT_REPEAT_EN
            r_shown  <= 1'b0;
`endif
        end else begin
            r_fill   <= w_fill_next;
            r_rd_idx <= w_rd_idx_post;
`ifdef HQ2X_SCANOUT_REPEAT_EN
            r_shown  <= r_shown | w_release;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (clr_flags) begin
                overflow <= 1'b0;
            end else if (wr_done && !w_wr_ready) begin
                overflow <= 1'b1;
            end
            if (clr_flags) begin
                underrun <= 1'b0;
            end else if (line_start && (w_fill_post == 3'd0)) begin
                underrun <= 1'b1;
            end
        end
    end

    // Line sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_repeat <= 1'b0;
            rdaddr   <= '0;
            rdbuf    <= 2'd0;
        end else if (line_start) begin
            r_cnt    <= '0;
            rdaddr   <= '0;
            r_repeat <= 1'b0;
            if (w_fill_post != 3'd0) begin
                r_state <= S_ACTIVE;
                rdbuf   <= w_rd_idx_post;
            end else if (w_start_repeat) begin
                r_state  <= S_ACTIVE;
                r_repeat <= 1'b1;
                rdbuf    <= w_rd_idx_post - 2'd1;
            end else begin
                r_state <= S_BLANK;
            end
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_state == S_ACTIVE) begin
                rdaddr <= rdaddr + (AWIDTH + 1)'(1);
            end
            if (w_last) begin
                r_state  <= S_IDLE;
                r_repeat <= 1'b0;
                rdaddr   <= '0;
            end
        end
    end

    // Two-stage output: the buffer returns q one clk after the strobe, and
    // the pixel is registered on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_v     <= 1'b0;
            r_rd_blank <= 1'b0;
            pix_valid  <= 1'b0;
            pix_out    <= '0;
        end else begin
            r_rd_v     <= w_accept;
            r_rd_blank <= (r_state == S_BLANK);
            pix_valid  <= r_rd_v;
            if (r_rd_v) begin
                pix_out <= r_rd_blank ? '0 : q;
            end
        end
    end

endmodule

// File: tb/tb_hq2x_scanout.sv
module tb_hq2x_scanout;

    localparam int LENGTH = 4;
    localparam int DWIDTH = 7;
    localparam int NW     = 2 * LENGTH;
`ifdef HQ2X_SCANOUT_REPEAT_EN
    localparam int MAXF   = 3;
    localparam bit REPEAT = 1'b1;
`else
    localparam int MAXF   = 4;
    localparam bit REPEAT = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic            wr_done;
    logic            wr_ready;
    logic            line_start;
    logic            ce_pix;
    logic [2:0]      rdaddr;
    logic [1:0]      rdbuf;
    logic [DWIDTH:0] q;
    logic [DWIDTH:0] pix_out;
    logic            pix_valid;
    logic            underrun;
    logic            overflow;
    logic            clr_flags;

    hq2x_scanout #(.LENGTH(LENGTH), .DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_done    (wr_done),
        .wr_ready   (wr_ready),
        .line_start (line_start),
        .ce_pix     (ce_pix),
        .rdaddr     (rdaddr),
        .rdbuf      (rdbuf),
        .q          (q),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .underrun   (underrun),
        .overflow   (overflow),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer: bank b, address a holds 16*b+a; synchronous read.
    always @(posedge clk) q <= 8'(16 * int'(rdbuf) + int'(rdaddr));

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int data;
        int due;
    } exp_t;
    exp_t exp_q[$];

    int pend[$];            // completed banks, oldest first; front is on screen
    int wr_bank    = 0;
    int line_bank  = -2;    // -2 no line, -1 blank line, else bank shown
    int words      = 0;
    bit line_rep   = 1'b0;
    int last_shown = -1;
    bit m_und      = 1'b0;
    bit m_ovf      = 1'b0;

    function automatic void model_reset();
        pend.delete();
        exp_q.delete();
        wr_bank    = 0;
        line_bank  = -2;
        words      = 0;
        line_rep   = 1'b0;
        last_shown = -1;
        m_und      = 1'b0;
        m_ovf      = 1'b0;
    endfunction

    function automatic void model_release();
        last_shown = pend.pop_front();
    endfunction

    // Called just before the edge that samples these inputs.
    function automatic void model_step(input bit wd, input bit ls, input bit ce, input bit clr);
        bit full;
        exp_t e;
        full = (pend.size() >= MAXF);
        if (ce && !ls && line_bank != -2) begin
            e.data = (line_bank < 0) ? 0 : 16 * line_bank + words;
            e.due  = edge_cnt + 2;
            exp_q.push_back(e);
            words++;
            if (words == NW) begin
                if (line_bank >= 0 && !line_rep) model_release();
                line_bank = -2;
            end
        end
        if (ls) begin
            if (line_bank >= 0 && !line_rep) model_release();
            words    = 0;
            line_rep = 1'b0;
            if (pend.size() > 0) begin
                line_bank = pend[0];
            end else begin
                m_und = 1'b1;
                if (REPEAT && last_shown >= 0) begin
                    line_bank = last_shown;
                    line_rep  = 1'b1;
                end else begin
                    line_bank = -1;
                end
            end
        end
        if (wd) begin
            if (!full) begin
                pend.push_back(wr_bank);
                wr_bank = (wr_bank + 1) % 4;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (clr) begin
            m_und = 1'b0;
            m_ovf = 1'b0;
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        logic [DWIDTH:0] last_pix;
        last_pix = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) last_pix = '0;
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                e = exp_q.pop_front();
                check("pix_valid", {31'd0, pix_valid}, 32'd1);
                check("pix_out", {24'd0, pix_out}, e.data);
                last_pix = pix_out;
            end else begin
                check("no_spurious_valid", {31'd0, pix_valid}, 32'd0);
                check("pix_hold", {24'd0, pix_out}, {24'd0, last_pix});
            end
            check("wr_ready", {31'd0, wr_ready}, (pend.size() < MAXF) ? 32'd1 : 32'd0);
            check("underrun", {31'd0, underrun}, {31'd0, m_und});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit wd, input bit ls, input bit ce, input bit clr);
        @(negedge clk);
        #1;
        wr_done    = wd;
        line_start = ls;
        ce_pix     = ce;
        clr_flags  = clr;
        model_step(wd, ls, ce, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic play_line(input int n_ce);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (n_ce) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n    = 1'b0;
        wr_done    = 1'b0;
        line_start = 1'b0;
        ce_pix     = 1'b0;
        clr_flags  = 1'b0;
        #1;
        check("rst_rdaddr", {29'd0, rdaddr}, 32'd0);
        check("rst_rdbuf", {30'd0, rdbuf}, 32'd0);
        check("rst_pix_out", {24'd0, pix_out}, 32'd0);
        check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : driver
        reset_n    = 1'b0;
        wr_done    = 1'b0;
        line_start = 1'b0;
        ce_pix     = 1'b0;
        clr_flags  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Normal line from bank 0, then a line from bank 1.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        play_line(NW);
        idle(4);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        play_line(NW);
        idle(4);

        // Fill to the limit, one extra write overflows, then clear.
        repeat (MAXF + 1) drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Drain to two pending, then write coinciding with the last strobe.
        while (pend.size() > 2) begin
            play_line(NW);
            idle(1);
        end
        play_line(NW - 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Drain everything, then an underrun line.
        while (pend.size() > 0) begin
            play_line(NW);
            idle(1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        play_line(NW);
        idle(4);

        // Aborted line with two banks pending.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        play_line(3);
        play_line(NW);
        idle(4);

        // Reset in the middle of a line; next line underruns.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        play_line(4);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle(2);
        play_line(NW);
        idle(4);

        // Random traffic, including back-to-back and ignored strobes.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(5) == 0, $urandom_range(29) == 0,
                  $urandom_range(3) != 0, $urandom_range(49) == 0);
        end
        idle(5);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
